afifo_wr_arbiter: RTL

// - Shares the 8-bit async-FIFO write port (wdata/winc/wfull) between NUM_REQ requesters in the wclk domain.
// - Round-robin grant with bounded bursts, valid/ready handshake per requester, and stall on wfull.
// - Sits between the write-side producers and the FIFO write interface; the read side is untouched.

---
 rtl/afifo_wr_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/afifo_wr_arbiter.sv
// rtl/afifo_wr_arbiter.sv - round-robin, burst-bounded arbiter for the async-FIFO write port
// Optional build: AFIFO_ARB_PKT_LOCK_EN adds req_last and holds the grant until the end of a packet.
module afifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       wclk,
    input  logic                       wrst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
`ifdef AFIFO_ARB_PKT_LOCK_EN
    input  logic [NUM_REQ-1:0]         req_last,
`endif
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       wfull,
    output logic                       winc,
    output logic [DATA_W-1:0]          wdata,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t          state_q, state_d;
    logic            grant_valid_q, grant_valid_d;
    logic [ID_W-1:0] grant_id_q, grant_id_d;
    logic [ID_W-1:0] rr_last_q, rr_last_d;
    logic [3:0]      beat_cnt_q, beat_cnt_d;

    logic            arb_found;
    logic [ID_W-1:0] arb_winner;
    logic [ID_W-1:0] arb_idx;
    logic            xfer;
    logic            release_now;

    logic [DATA_W-1:0] req_data_a [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_data_a[gi] = req_data[gi*DATA_W +: DATA_W];
    end

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        arb_found  = 1'b0;
        arb_winner = '0;
        arb_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            arb_idx = ID_W'((int'(rr_last_q) + k) % NUM_REQ);
            if (!arb_found && req_valid[arb_idx]) begin
                arb_found  = 1'b1;
                arb_winner = arb_idx;
            end
        end
    end

    always_comb begin
        xfer      = grant_valid_q & req_valid[grant_id_q] & ~wfull;
        winc      = xfer;
        req_ready = '0;
        if (xfer) begin
            req_ready[grant_id_q] = 1'b1;
        end
        wdata = grant_valid_q ? req_data_a[grant_id_q] : '0;
    end

`ifdef AFIFO_ARB_PKT_LOCK_EN
    // Packet lock: only the final beat of a packet ends the grant.
    always_comb begin
        release_now = xfer & req_last[grant_id_q];
    end
`else
    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    always_comb begin
        release_now = (xfer && (beat_cnt_q == LAST_BEAT)) || !req_valid[grant_id_q];
    end
`endif

    always_comb begin
        state_d       = state_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        rr_last_d     = rr_last_q;
        beat_cnt_d    = beat_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    state_d       = S_GRANT;
                    grant_valid_d = 1'b1;
                    grant_id_d    = arb_winner;
                    rr_last_d     = arb_winner;
                    beat_cnt_d    = '0;
                end
            end
            S_GRANT: begin
                if (xfer) begin
`ifdef AFIFO_ARB_PKT_LOCK_EN
                    if (beat_cnt_q != 4'hF) begin
                        beat_cnt_d = beat_cnt_q + 4'd1;
                    end
`else
                    beat_cnt_d = beat_cnt_q + 4'd1;
`endif
                end
                if (release_now) begin
                    state_d       = S_IDLE;
                    grant_valid_d = 1'b0;
                end
            end
            default: begin
                state_d       = S_IDLE;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q       <= S_IDLE;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            rr_last_q     <= ID_W'(NUM_REQ - 1);
            beat_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            rr_last_q     <= rr_last_d;
            beat_cnt_q    <= beat_cnt_d;
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;

endmodule
